bus_uart_tx: RTL and testbench



---
 rtl/bus_uart_pkg.sv | 28 ++
 rtl/bus_uart_tx_sync_fifo.sv | 54 +++++
 rtl/bus_uart_tx.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_bus_uart_tx.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_uart_pkg.sv
// bus_uart_pkg
// Shared definitions for the memory-mapped UART transmitter:
//   - register offsets inside the 4-byte bus window
//   - STATUS register bit positions
//   - transmitter FSM state encoding
// Optional feature macro: UART_TX_PARITY_EN (adds an even-parity bit to every frame).
package bus_uart_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DIV_LO = 2'd2;
  localparam logic [1:0] REG_DIV_HI = 2'd3;

  localparam int STAT_IDLE_BIT   = 0;
  localparam int STAT_FULL_BIT   = 1;
  localparam int STAT_BUSY_BIT   = 2;
  localparam int STAT_OVF_BIT    = 3;
  localparam int STAT_PARITY_BIT = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

endpackage

// File: rtl/bus_uart_tx_sync_fifo.sv
// sync_fifo
// Single-clock FIFO with synchronous active-high reset.
// Pointers carry one extra wrap bit, so full/empty are told apart by the MSBs.
// Ports:
//   i_clk, i_reset : clock and synchronous reset (reset empties the FIFO)
//   push, wdata    : write request and data (ignored while full)
//   pop            : read request, advances the read pointer (ignored while empty)
//   rdata          : head-of-queue data, valid whenever empty is low
//   full, empty    : occupancy flags
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wrPtr_q;
  logic [AW:0]      rdPtr_q;

  assign empty = (wrPtr_q == rdPtr_q);
  assign full  = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
  assign rdata = mem_q[rdPtr_q[AW-1:0]];

  always_ff @(posedge i_clk) begin
    if (push && !full) begin
      mem_q[wrPtr_q[AW-1:0]] <= wdata;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      if (push && !full) begin
        wrPtr_q <= wrPtr_q + (AW+1)'(1);
      end
      if (pop && !empty) begin
        rdPtr_q <= rdPtr_q + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/bus_uart_tx.sv
// bus_uart_tx
// UART transmitter sitting on the 6502-style external bus as a target.
// The CPU fills a TX FIFO through a 4-byte window; a baud-divider FSM
// sends the bytes as 8N1 frames (or 8E1 when UART_TX_PARITY_EN is defined).
// Ports:
//   i_clk, i_reset : system clock, synchronous active-high reset
//   i_phi2         : bus phase 2 (synchronous to i_clk)
//   i_addr, i_data : bus address and write data
//   i_rw, i_en     : 1 = read / 0 = write, bus enable
//   o_data, o_sel  : registered read data and window-hit flag for the read mux
//   o_txd          : serial output, idles high
// Optional feature macro: UART_TX_PARITY_EN.
module bus_uart_tx
  import bus_uart_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR   = 16'hD000,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd0
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_phi2,
  input  logic [15:0] i_addr,
  input  logic [7:0]  i_data,
  input  logic        i_rw,
  input  logic        i_en,
  output logic [7:0]  o_data,
  output logic        o_sel,
  output logic        o_txd
);

  logic       hit;
  logic       phi2_q;
  logic [1:0] capOff_q;
  logic [7:0] capData_q;
  logic       capRw_q;
  logic       capHit_q;
  logic       commit;
  logic       wrData;
  logic       wrStatus;

  logic [15:0] div_q;
  logic        overflow_q;
  logic [7:0]  lastData_q;
  logic [7:0]  rdData_q;
  logic        sel_q;
  logic [7:0]  status;
  logic [7:0]  readMux;

  logic       fifoPush;
  logic       fifoPop;
  logic       fifoFull;
  logic       fifoEmpty;
  logic [7:0] fifoRdata;

  tx_state_t   state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic [15:0] divLatch_q, divLatch_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  bitCnt_q, bitCnt_d;
  logic        txd_q, txd_d;
  logic        bitDone;
  logic        startFrame;
`ifdef UART_TX_PARITY_EN
  logic        parity_q, parity_d;
`endif

  assign hit = i_en & (i_addr[15:2] == BASE_ADDR[15:2]);

  // A write commits once, on the falling edge of phi2, using whatever was
  // captured during the last clock that phi2 was high.
  assign commit   = phi2_q & ~i_phi2 & ~capRw_q & capHit_q;
  assign wrData   = commit && (capOff_q == REG_DATA);
  assign wrStatus = commit && (capOff_q == REG_STATUS);

  // full is the pre-pop value, so a push colliding with a pop of a full FIFO drops.
  assign fifoPush = wrData & ~fifoFull;

  sync_fifo #(
    .WIDTH(8),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .push   (fifoPush),
    .pop    (fifoPop),
    .wdata  (capData_q),
    .rdata  (fifoRdata),
    .full   (fifoFull),
    .empty  (fifoEmpty)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      phi2_q     <= 1'b0;
      capOff_q   <= 2'd0;
      capData_q  <= 8'd0;
      capRw_q    <= 1'b1;
      capHit_q   <= 1'b0;
      div_q      <= DEFAULT_DIV;
      overflow_q <= 1'b0;
      lastData_q <= 8'd0;
    end else begin
      phi2_q <= i_phi2;
      if (i_phi2) begin
        capOff_q  <= i_addr[1:0];
        capData_q <= i_data;
        capRw_q   <= i_rw;
        capHit_q  <= hit;
      end
      if (wrData) begin
        lastData_q <= capData_q;
        if (fifoFull) begin
          overflow_q <= 1'b1;
        end
      end
      if (wrStatus && capData_q[STAT_OVF_BIT]) begin
        overflow_q <= 1'b0;
      end
      if (commit && (capOff_q == REG_DIV_LO)) begin
        div_q[7:0] <= capData_q;
      end
      if (commit && (capOff_q == REG_DIV_HI)) begin
        div_q[15:8] <= capData_q;
      end
    end
  end

  always_comb begin
    status                  = 8'h00;
    status[STAT_IDLE_BIT]   = fifoEmpty & (state_q == IDLE);
    status[STAT_FULL_BIT]   = fifoFull;
    status[STAT_BUSY_BIT]   = (state_q != IDLE);
    status[STAT_OVF_BIT]    = overflow_q;
`ifdef UART_TX_PARITY_EN
    status[STAT_PARITY_BIT] = 1'b1;
`endif
  end

  always_comb begin
    readMux = 8'h00;
    if (hit) begin
      case (i_addr[1:0])
        REG_DATA:   readMux = lastData_q;
        REG_STATUS: readMux = status;
        REG_DIV_LO: readMux = div_q[7:0];
        default:    readMux = div_q[15:8];
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rdData_q <= 8'h00;
      sel_q    <= 1'b0;
    end else begin
      rdData_q <= readMux;
      sel_q    <= hit & i_rw;
    end
  end

  assign o_data = rdData_q;
  assign o_sel  = sel_q;

  // Each bit lasts until the down-counting timer reaches zero, i.e. DIV+1 clocks.
  assign bitDone = (timer_q == 16'd0);

  // A new frame starts from IDLE, or straight out of STOP when more data waits.
  assign startFrame = !fifoEmpty &&
                      ((state_q == IDLE) || ((state_q == STOP) && bitDone));

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    divLatch_d = divLatch_q;
    shift_d    = shift_q;
    bitCnt_d   = bitCnt_q;
    fifoPop    = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d   = parity_q;
`endif

    case (state_q)
      IDLE: begin
        timer_d = timer_q;
      end
      START: begin
        if (bitDone) begin
          timer_d = divLatch_q;
          state_d = DATA;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      DATA: begin
        if (bitDone) begin
          timer_d  = divLatch_q;
          shift_d  = {1'b0, shift_q[7:1]};
          bitCnt_d = bitCnt_q + 3'd1;
          if (bitCnt_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      PARITY: begin
        if (bitDone) begin
          timer_d = divLatch_q;
          state_d = STOP;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      STOP: begin
        if (bitDone) begin
          state_d = IDLE;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // The divisor is sampled only here, so mid-frame DIV writes wait for the next frame.
    if (startFrame) begin
      fifoPop    = 1'b1;
      shift_d    = fifoRdata;
      divLatch_d = div_q;
      timer_d    = div_q;
      bitCnt_d   = 3'd0;
      state_d    = START;
`ifdef UART_TX_PARITY_EN
      parity_d   = ^fifoRdata;
`endif
    end

    // The line level is registered alongside the state it belongs to.
    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  txd_d = parity_d;
`endif
      default: txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= IDLE;
      timer_q    <= 16'd0;
      divLatch_q <= 16'd0;
      shift_q    <= 8'd0;
      bitCnt_q   <= 3'd0;
      txd_q      <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      divLatch_q <= divLatch_d;
      shift_q    <= shift_d;
      bitCnt_q   <= bitCnt_d;
      txd_q      <= txd_d;
`ifdef UART_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

  assign o_txd = txd_q;

endmodule

// File: tb/tb_bus_uart_tx.sv
// tb_bus_uart_tx
// Self-checking bench for bus_uart_tx: a table of register-access vectors
// followed by hand-written multi-cycle sequences for framing, back-to-back
// frames, FIFO overflow, divisor latching and reset mid-frame.
// Honours UART_TX_PARITY_EN for frame length and STATUS bit4.
module tb_bus_uart_tx;

`ifdef UART_TX_PARITY_EN
  localparam int         FRAME_BITS = 11;
  localparam logic [7:0] PAR_FLAG   = 8'h10;
`else
  localparam int         FRAME_BITS = 10;
  localparam logic [7:0] PAR_FLAG   = 8'h00;
`endif

  localparam logic [15:0] A_DATA   = 16'hD000;
  localparam logic [15:0] A_STATUS = 16'hD001;
  localparam logic [15:0] A_DIVLO  = 16'hD002;
  localparam logic [15:0] A_DIVHI  = 16'hD003;

  logic        clk;
  logic        reset;
  logic        phi2;
  logic [15:0] addr;
  logic [7:0]  data;
  logic        rw;
  logic        en;
  logic [7:0]  o_data;
  logic        o_sel;
  logic        o_txd;

  int checks;
  int failures;
  bit statusOn;

  typedef struct {
    logic [15:0] addr;
    logic        en;
    logic        wr;
    logic [7:0]  wdata;
    logic [7:0]  expData;
    logic        expSel;
  } vec_t;

  vec_t vecs [16];

  bus_uart_tx #(
    .BASE_ADDR  (16'hD000),
    .FIFO_DEPTH (8),
    .DEFAULT_DIV(16'd0)
  ) dut (
    .i_clk  (clk),
    .i_reset(reset),
    .i_phi2 (phi2),
    .i_addr (addr),
    .i_data (data),
    .i_rw   (rw),
    .i_en   (en),
    .o_data (o_data),
    .o_sel  (o_sel),
    .o_txd  (o_txd)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Guard against a stuck run.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] a, input logic [7:0] d, input logic e);
    @(negedge clk);
    addr = a; data = d; rw = 1'b0; en = e; phi2 = 1'b1;
    @(negedge clk);
    phi2 = 1'b0; en = 1'b0; rw = 1'b1;
    @(negedge clk);
  endtask

  task automatic busRead(input logic [15:0] a, input logic e, output logic [7:0] d, output logic s);
    @(negedge clk);
    addr = a; rw = 1'b1; en = e; phi2 = 1'b0;
    @(negedge clk);
    d = o_data; s = o_sel;
    en = 1'b0;
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic checkStatus(input string name, input logic [7:0] exp);
    logic [7:0] d;
    logic       s;
    busRead(A_STATUS, 1'b1, d, s);
    checkOutput(name, {23'd0, s, d}, {23'd0, 1'b1, exp});
  endtask

  // Waits for a start bit (unless it must appear on the very next clock)
  // then checks every clock of the frame against the expected bit sequence.
  task automatic expectFrame(input logic [7:0] b, input int div, input bit immediate, input string tag);
    logic [10:0] bits;
    int waited;
    bits = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = b[i];
`ifdef UART_TX_PARITY_EN
    bits[9] = ^b;
`endif
    bits[FRAME_BITS-1] = 1'b1;
    @(posedge clk); #2;
    waited = 0;
    if (!immediate) begin
      while (o_txd !== 1'b0 && waited < 500) begin
        @(posedge clk); #2;
        waited++;
      end
    end
    checkOutput({tag, " start"}, {31'd0, o_txd}, 32'd0);
    if (o_txd !== 1'b0) return;
    for (int k = 0; k < FRAME_BITS; k++) begin
      for (int c = 0; c <= div; c++) begin
        if (k != 0 || c != 0) begin
          @(posedge clk); #2;
          checkOutput($sformatf("%s bit%0d clk%0d", tag, k, c), {31'd0, o_txd}, {31'd0, bits[k]});
        end
        if (statusOn) begin
          checkOutput($sformatf("%s busy bit%0d", tag, k), {31'd0, o_data[2]}, 32'd1);
        end
      end
    end
  endtask

  initial begin
    logic [7:0] rd;
    logic       rs;
    int         highCnt;

    checks = 0; failures = 0; statusOn = 1'b0;
    reset = 1'b1; phi2 = 1'b0; addr = 16'h0000; data = 8'h00; rw = 1'b1; en = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset txd", {31'd0, o_txd}, 32'd1);
    checkOutput("reset sel", {31'd0, o_sel}, 32'd0);
    checkOutput("reset data", {24'd0, o_data}, 32'd0);
    reset = 1'b0;

    // Register-access vectors: {addr, en, write, wdata, expected data, expected sel}
    vecs[0]  = '{A_STATUS, 1'b1, 1'b0, 8'h00, 8'h01 | PAR_FLAG, 1'b1};
    vecs[1]  = '{A_DIVLO,  1'b1, 1'b1, 8'h34, 8'h00, 1'b0};
    vecs[2]  = '{A_DIVLO,  1'b1, 1'b0, 8'h00, 8'h34, 1'b1};
    vecs[3]  = '{A_DIVHI,  1'b1, 1'b1, 8'h12, 8'h00, 1'b0};
    vecs[4]  = '{A_DIVHI,  1'b1, 1'b0, 8'h00, 8'h12, 1'b1};
    vecs[5]  = '{A_DATA,   1'b1, 1'b0, 8'h00, 8'h00, 1'b1};
    vecs[6]  = '{16'hD006, 1'b1, 1'b1, 8'hEE, 8'h00, 1'b0};
    vecs[7]  = '{A_DIVLO,  1'b1, 1'b0, 8'h00, 8'h34, 1'b1};
    vecs[8]  = '{16'hD006, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0};
    vecs[9]  = '{A_DIVLO,  1'b0, 1'b1, 8'hAB, 8'h00, 1'b0};
    vecs[10] = '{A_DIVLO,  1'b1, 1'b0, 8'h00, 8'h34, 1'b1};
    vecs[11] = '{A_DIVLO,  1'b0, 1'b0, 8'h00, 8'h00, 1'b0};
    vecs[12] = '{A_DIVHI,  1'b1, 1'b1, 8'h00, 8'h00, 1'b0};
    vecs[13] = '{A_DIVLO,  1'b1, 1'b1, 8'h03, 8'h00, 1'b0};
    vecs[14] = '{A_DIVHI,  1'b1, 1'b0, 8'h00, 8'h00, 1'b1};
    vecs[15] = '{16'hCFFE, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0};

    for (int i = 0; i < 16; i++) begin
      if (vecs[i].wr) begin
        applyStimulus(vecs[i].addr, vecs[i].wdata, vecs[i].en);
      end else begin
        busRead(vecs[i].addr, vecs[i].en, rd, rs);
        checkOutput($sformatf("vec%0d data", i), {24'd0, rd}, {24'd0, vecs[i].expData});
        checkOutput($sformatf("vec%0d sel", i), {31'd0, rs}, {31'd0, vecs[i].expSel});
      end
    end

    // DIV=3 single frame
    applyStimulus(A_DATA, 8'hA5, 1'b1);
    expectFrame(8'hA5, 3, 1'b0, "t2");
    repeat (2) @(posedge clk);
    checkStatus("t2 status", 8'h01 | PAR_FLAG);
    busRead(A_DATA, 1'b1, rd, rs);
    checkOutput("t2 last data", {24'd0, rd}, 32'h0000_00A5);

    // DIV=0, three frames back to back with busy polled after the writes
    applyStimulus(A_DIVLO, 8'h00, 1'b1);
    fork
      begin
        applyStimulus(A_DATA, 8'h00, 1'b1);
        applyStimulus(A_DATA, 8'hFF, 1'b1);
        applyStimulus(A_DATA, 8'h55, 1'b1);
        addr = A_STATUS; rw = 1'b1; en = 1'b1;
        statusOn = 1'b1;
      end
      begin
        expectFrame(8'h00, 0, 1'b0, "t3f1");
        expectFrame(8'hFF, 0, 1'b1, "t3f2");
        expectFrame(8'h55, 0, 1'b1, "t3f3");
      end
    join
    statusOn = 1'b0;
    en = 1'b0;
    repeat (2) @(posedge clk);
    checkStatus("t3 status", 8'h01 | PAR_FLAG);

    // Overflow with a slow divisor holding the FSM busy
    applyStimulus(A_DIVLO, 8'hFF, 1'b1);
    applyStimulus(A_DIVHI, 8'hFF, 1'b1);
    applyStimulus(A_DATA, 8'h11, 1'b1);
    for (int i = 0; i < 8; i++) applyStimulus(A_DATA, 8'h20 + 8'(i), 1'b1);
    checkStatus("t4 full", 8'h06 | PAR_FLAG);
    busRead(A_DATA, 1'b1, rd, rs);
    checkOutput("t4 last data", {24'd0, rd}, 32'h0000_0027);
    applyStimulus(A_DATA, 8'h99, 1'b1);
    checkStatus("t4 overflow", 8'h0E | PAR_FLAG);
    applyStimulus(A_STATUS, 8'h00, 1'b1);
    checkStatus("t4 ovf kept", 8'h0E | PAR_FLAG);
    applyStimulus(A_STATUS, 8'h08, 1'b1);
    checkStatus("t4 ovf clear", 8'h06 | PAR_FLAG);
    doReset();
    checkStatus("t4 after reset", 8'h01 | PAR_FLAG);

    // Divisor change mid-frame applies to the following frame only
    applyStimulus(A_DIVLO, 8'h01, 1'b1);
    fork
      begin
        applyStimulus(A_DATA, 8'h3C, 1'b1);
        applyStimulus(A_DATA, 8'h07, 1'b1);
        applyStimulus(A_DIVLO, 8'h07, 1'b1);
      end
      begin
        expectFrame(8'h3C, 1, 1'b0, "t5f1");
        expectFrame(8'h07, 7, 1'b1, "t5f2");
      end
    join

    // Reset on the 5th clock of DATA
    applyStimulus(A_DIVLO, 8'h03, 1'b1);
    fork
      begin
        applyStimulus(A_DATA, 8'hA5, 1'b1);
        applyStimulus(A_DATA, 8'h33, 1'b1);
      end
      begin
        int waited;
        waited = 0;
        @(posedge clk); #2;
        while (o_txd !== 1'b0 && waited < 500) begin
          @(posedge clk); #2;
          waited++;
        end
        checkOutput("t6 start", {31'd0, o_txd}, 32'd0);
        repeat (8) begin
          @(posedge clk); #2;
        end
        checkOutput("t6 data bit1", {31'd0, o_txd}, 32'd0);
        reset = 1'b1;
        @(posedge clk); #2;
        checkOutput("t6 txd after reset", {31'd0, o_txd}, 32'd1);
        reset = 1'b0;
      end
    join
    checkStatus("t6 status", 8'h01 | PAR_FLAG);
    highCnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #2;
      if (o_txd === 1'b1) highCnt++;
    end
    checkOutput("t6 line idle", highCnt, 32'd100);
    checkStatus("t6 status end", 8'h01 | PAR_FLAG);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
